ctrl_unit_pipe: RTL

Registered, condition-aware control unit for the ID stage of the 5-stage ARM-subset pipeline. It decodes opcode/mode/S/cond into EX/MEM/WB control signals and gates them against the NZCV status flags. It applies stall and flush from the hazard and branch logic, and inserts issue bubbles after multi-cycle operations (MUL). Its outputs form the control half of the ID/EX pipeline register.

---
 rtl/ctrl_unit_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_unit_pipe.sv
// ID-stage control unit: decodes opcode/mode/S/cond into registered EX/MEM/WB
// controls, gates them on NZCV, and inserts issue bubbles behind multi-cycle MULs.
module ctrl_unit_pipe #(
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic [1:0]       mode,
  input  logic             s,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             wb_en,
  output logic             mem_r,
  output logic             mem_w,
  output logic             b,
  output logic             s_out,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RAW_W = 4;
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);

  logic [CNT_W-1:0] mul_cnt;

  logic             dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_ill, dec_mul;
  logic [RAW_W-1:0] dec_cmd;
  logic             cond_pass;
  logic             accept;

  // Raw instruction decode, before condition gating.
  always_comb begin
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_cmd = '0;
    case (mode)
      2'b00: begin
        dec_wb = 1'b1;
        dec_s  = s;
        case (opcode)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
            dec_cmd = 4'b0100;
          end
          4'b1000: begin
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
            dec_cmd = 4'b0110;
          end
          default: begin
            dec_wb  = 1'b0;
            dec_s   = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      2'b01: begin
        if (opcode == 4'b0100) begin
          dec_wb  = s;
          dec_mr  = s;
          dec_mw  = ~s;
          dec_cmd = 4'b0010;
        end else begin
          dec_ill = 1'b1;
        end
      end
      2'b10: dec_b = 1'b1;
      default: begin
        if (opcode == 4'b0000) begin
          dec_wb  = 1'b1;
          dec_s   = s;
          dec_cmd = 4'b1010;
          dec_mul = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
    endcase
  end

  // ARM condition evaluation against {N,Z,C,V}.
  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'b0000: cond_pass = status[2];
      4'b0001: cond_pass = ~status[2];
      4'b0010: cond_pass = status[1];
      4'b0011: cond_pass = ~status[1];
      4'b0100: cond_pass = status[3];
      4'b0101: cond_pass = ~status[3];
      4'b0110: cond_pass = status[0];
      4'b0111: cond_pass = ~status[0];
      4'b1000: cond_pass = status[1] & ~status[2];
      4'b1001: cond_pass = ~status[1] | status[2];
      4'b1010: cond_pass = (status[3] == status[0]);
      4'b1011: cond_pass = (status[3] != status[0]);
      4'b1100: cond_pass = ~status[2] & (status[3] == status[0]);
      4'b1101: cond_pass = status[2] | (status[3] != status[0]);
      default: cond_pass = 1'b1;
    endcase
  end

  assign busy   = (mul_cnt != '0);
  assign accept = in_valid & ~stall & ~busy;

  // ID/EX control register and MUL occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      b         <= 1'b0;
      s_out     <= 1'b0;
      exe_cmd   <= '0;
      illegal   <= 1'b0;
      mul_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      b         <= 1'b0;
      s_out     <= 1'b0;
      exe_cmd   <= '0;
      illegal   <= 1'b0;
      mul_cnt   <= '0;
    end else if (stall) begin
      mul_cnt   <= mul_cnt;
    end else if (accept) begin
      // A failed condition still occupies the slot, but as a no-op.
      out_valid <= 1'b1;
      wb_en     <= cond_pass & dec_wb;
      mem_r     <= cond_pass & dec_mr;
      mem_w     <= cond_pass & dec_mw;
      b         <= cond_pass & dec_b;
      s_out     <= cond_pass & dec_s;
      exe_cmd   <= cond_pass ? CMD_W'(dec_cmd) : '0;
      illegal   <= cond_pass & dec_ill;
      mul_cnt   <= (cond_pass & dec_mul) ? MUL_RELOAD : '0;
    end else begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      b         <= 1'b0;
      s_out     <= 1'b0;
      exe_cmd   <= '0;
      illegal   <= 1'b0;
      if (busy) mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end

endmodule
